strike_core: RTL
================

Name: strike_core

Overview:
- Parametrised second-generation strike processor core: multi-cycle fetch/decode/execute FSM, accumulator, zero flag, conditional jump, programmable-delay WAIT.
- Program ROM is external to the core: address out, synchronous data in, 1-cycle read latency.
- Drives an LED output register and a halt indicator.
- Sits between the board top level and a genrom instance.

Parameters:
- AW, 6: address/immediate width; PC, accumulator and instruction operand field are AW bits.
- LEDW, 4: LED register width; must satisfy 1 <= LEDW <= AW.
- WAIT_DIV, 4: clock cycles per WAIT unit; must be >= 1.
- Derived (localparam, not overridable): IW = AW+3 instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- rom_addr  out  AW  ROM address; equals PC combinationally.
- rom_data  in  IW  ROM word; valid 1 cycle after rom_addr.
- hold  in  1  when 1, core stalls in FETCH before starting a new instruction.
- leds  out  LEDW  LED register.
- stop  out  1  1 once HALT has executed.
- fetch_strobe  out  1  1-cycle pulse in LOADIR; the instruction at PC is being latched.

Behaviour:
- Reset (rstn=0 sampled at an edge) sets:
  - PC=0, IR=0, ACC=0, ZF=1
  - leds=0, stop=0, fetch_strobe=0
  - wait counters=0, state=FETCH
- Reset wins over every other event, including in WAITING and HALTED.
- Instruction format: OP=IR[IW-1:AW], K=IR[AW-1:0]. Opcodes:
  - 0 WAIT: stall K*WAIT_DIV cycles.
  - 1 HALT.
  - 2 LEDS: leds<=K[LEDW-1:0].
  - 3 JP: PC<=K.
  - 4 LDA: ACC<=K, ZF<=(K==0).
  - 5 ADD: ACC<=(ACC+K) mod 2^AW, ZF<=(result==0); carry discarded.
  - 6 JZ: if ZF then PC<=K.
  - 7 OUT: leds<=ACC[LEDW-1:0].
- FSM states: FETCH, LOADIR, EXEC, WAITING, HALTED.
  - FETCH: rom_addr=PC. If hold=1, stay in FETCH. Otherwise go to LOADIR.
  - LOADIR: IR<=rom_data; PC<=PC+1 (wraps 2^AW-1 to 0); fetch_strobe=1; go to EXEC.
  - EXEC: performs the opcode. JP and taken JZ override the incremented PC. Untaken JZ leaves PC unchanged.
  - EXEC next state: HALT goes to HALTED. WAIT with K!=0 loads the unit counter=K and prescaler=WAIT_DIV-1, then goes to WAITING. Everything else, including WAIT with K=0, goes to FETCH.
- Timing:
  - Non-stalling instructions take exactly 3 cycles.
  - Register effects (leds, ACC, ZF, PC jump) become visible after the EXEC edge.
- WAITING:
  - Prescaler counts down each cycle. At 0 it reloads WAIT_DIV-1 and the unit counter decrements.
  - When the unit counter reaches 0 (at prescaler 0), go to FETCH.
  - WAITING lasts exactly K*WAIT_DIV cycles; a WAIT instruction totals 3+K*WAIT_DIV cycles.
  - hold is ignored in WAITING.
- HALTED:
  - stop=1 from the EXEC edge onward.
  - PC, ACC, leds frozen; rom_addr stays at PC; fetch_strobe=0.
  - Only reset exits HALTED.
- hold:
  - Sampled only in FETCH; never aborts an instruction already in LOADIR or EXEC.
  - hold may be held high indefinitely with no state change.
- Jump boundaries: JP/JZ to own address is legal (tight loop). Jump target 2^AW-1 followed by sequential execution wraps to 0.

Test Plan:
- Cycle reference: edge n = nth rising edge after rstn first sampled 1. Defaults AW=6, LEDW=4, WAIT_DIV=4.
- Reset release; ROM[0]=LEDS 5, ROM[1]=HALT:
  - leds=5 after edge 3; stop=1 after edge 6.
  - fetch_strobe high in cycles before edges 2 and 5.
  - PC=2 frozen; no further change over 50 cycles.
- ROM[0]=WAIT 3, ROM[1]=LEDS 1, ROM[2]=WAIT 0, ROM[3]=LEDS 2:
  - leds=1 after edge 18 (3+12+3).
  - leds=2 after edge 24 (WAIT 0 costs 3 cycles).
- ROM[0]=LDA 62, ROM[1]=ADD 2, ROM[2]=JZ 10, ROM[10]=OUT, ROM[11]=HALT:
  - ACC=0, ZF=1 after ADD; next fetch at rom_addr=10; final leds=0.
  - Repeat with ADD 1: ACC=63, JZ not taken, rom_addr=3.
- ROM[0]=JP 63, ROM[63]=LEDS 9, ROM[0] fetched again: after LEDS 9, PC wraps to 0; fetch_strobe sequence addresses 0,63,0.
- Drive hold=1 from reset for 10 cycles: state FETCH, rom_addr=0, no fetch_strobe. Release: first fetch_strobe one cycle later.
- Assert rstn=0 for one edge mid-WAITING (WAIT 63), then again after HALT: leds=0, stop=0, PC=0; execution restarts from ROM[0].

Source files
------------

// File: rtl/strike_core.sv
// strike_core: multi-cycle fetch/decode/execute processor core.
//   One accumulator, a zero flag, a conditional jump and a WAIT with a
//   programmable delay. The program ROM sits outside the core.
// Ports:
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   rom_addr     ROM address, always equal to PC
//   rom_data     ROM word, valid one cycle after rom_addr
//   hold         stalls the core in FETCH before it starts a new instruction
//   leds         LED output register
//   stop         high once HALT has executed
//   fetch_strobe one-cycle pulse while the instruction at PC is latched
// Parameters: AW address/immediate width, LEDW LED width (1..AW),
//   WAIT_DIV clock cycles per WAIT unit (>= 1).
module strike_core #(
  parameter int AW       = 6,
  parameter int LEDW     = 4,
  parameter int WAIT_DIV = 4
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [AW-1:0]   rom_addr,
  input  logic [AW+2:0]   rom_data,
  input  logic            hold,
  output logic [LEDW-1:0] leds,
  output logic            stop,
  output logic            fetch_strobe
);
  localparam int IW = AW + 3;
  // Prescaler counts WAIT_DIV-1 down to 0; keep at least one bit.
  localparam int PW = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(WAIT_DIV - 1);

  localparam logic [2:0] OP_WAIT = 3'd0;
  localparam logic [2:0] OP_HALT = 3'd1;
  localparam logic [2:0] OP_LEDS = 3'd2;
  localparam logic [2:0] OP_JP   = 3'd3;
  localparam logic [2:0] OP_LDA  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_JZ   = 3'd6;
  localparam logic [2:0] OP_OUT  = 3'd7;

  typedef enum logic [2:0] {FETCH, LOADIR, EXEC, WAITING, HALTED} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   pc, pc_nx;
  logic [AW-1:0]   acc, acc_nx;
  logic [AW-1:0]   units, units_nx;
  logic [PW-1:0]   presc, presc_nx;
  logic [IW-1:0]   ir, ir_nx;
  logic            zf, zf_nx;
  logic [LEDW-1:0] leds_nx;
  logic [2:0]      op;
  logic [AW-1:0]   k;
  logic [AW-1:0]   sum;

  assign op  = ir[IW-1:AW];
  assign k   = ir[AW-1:0];
  assign sum = acc + k;  // carry intentionally dropped

  assign rom_addr     = pc;
  assign fetch_strobe = (state == LOADIR);
  assign stop         = (state == HALTED);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    acc_nx   = acc;
    zf_nx    = zf;
    ir_nx    = ir;
    units_nx = units;
    presc_nx = presc;
    leds_nx  = leds;
    case (state)
      FETCH:  if (!hold) state_nx = LOADIR;
      LOADIR: begin
        ir_nx    = rom_data;
        pc_nx    = pc + 1'b1;
        state_nx = EXEC;
      end
      EXEC: begin
        state_nx = FETCH;
        case (op)
          OP_WAIT: if (k != '0) begin
            // WAIT 0 falls straight through to FETCH
            units_nx = k;
            presc_nx = PRE_TOP;
            state_nx = WAITING;
          end
          OP_HALT: state_nx = HALTED;
          OP_LEDS: leds_nx = k[LEDW-1:0];
          OP_JP:   pc_nx = k;
          OP_LDA: begin
            acc_nx = k;
            zf_nx  = (k == '0);
          end
          OP_ADD: begin
            acc_nx = sum;
            zf_nx  = (sum == '0);
          end
          OP_JZ:   if (zf) pc_nx = k;
          OP_OUT:  leds_nx = acc[LEDW-1:0];
        endcase
      end
      WAITING: begin
        // Leave on the cycle the last unit expires so the stall is
        // exactly K*WAIT_DIV cycles.
        if (presc == '0) begin
          presc_nx = PRE_TOP;
          units_nx = units - 1'b1;
          if (units == AW'(1)) state_nx = FETCH;
        end else begin
          presc_nx = presc - 1'b1;
        end
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= FETCH;
      pc    <= '0;
      acc   <= '0;
      zf    <= 1'b1;
      ir    <= '0;
      units <= '0;
      presc <= '0;
      leds  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      acc   <= acc_nx;
      zf    <= zf_nx;
      ir    <= ir_nx;
      units <= units_nx;
      presc <= presc_nx;
      leds  <= leds_nx;
    end
  end
endmodule
